seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: consecutive identical synchronized samples required before capture; legal range 2..255.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000000: idle clocks without a capture before stale is flagged; 28-bit counter.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port com, input, 4 bits: active-low digit select; 0111 thousands, 1011 hundreds, 1101 tens, 1110 units, 1111 blank.
REQ-006 SHALL have port num, input, 8 bits: active-low segments; num[7]=a down to num[1]=g, num[0]=dp.
REQ-007 SHALL have port digits, output, 16 bits: decoded values, [15:12] thousands down to [3:0] units.
REQ-008 SHALL have port dp, output, 4 bits: decimal point lit per position, bit 3 is thousands.
REQ-009 SHALL have port digit_err, output, 4 bits: per-position undecodable pattern flag.
REQ-010 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when digits, dp and digit_err update.
REQ-011 SHALL have port stale, output, 1 bit: level, high when the scan has stopped.

Function
REQ-012 SHALL pass com and num through a 2-flop synchronizer before any use.
REQ-013 SHALL treat a synchronized com with exactly one zero bit as legal; 1111 and multi-zero codes SHALL clear the settle counter and SHALL never be captured.
REQ-014 SHALL count consecutive clocks with unchanged legal {com,num}; when the count reaches SETTLE_CYCLES it SHALL capture exactly once per phase, with no re-capture until {com,num} changes.
REQ-015 SHALL decode captured segments (active-low, dp excluded): glyphs 0-9 map to 4'h0-4'h9; any other pattern SHALL yield 4'hF and set that position's error bit.
REQ-016 SHALL store each capture in a shadow slot selected by com and set that slot's bit in a 4-bit seen mask.
REQ-017 SHALL overwrite the shadow slot when the same position is captured again before frame completion, leaving the mask unchanged.
REQ-018 SHALL, on the clock after the seen mask becomes 1111, copy all shadow slots to digits/dp/digit_err, pulse frame_valid for one cycle, and clear the seen mask; the capture-to-frame_valid latency is 1 clock.
REQ-019 SHALL hold digits, dp and digit_err stable between frame_valid pulses.
REQ-020 SHALL clear the timeout counter on every capture.
REQ-021 SHALL, when the timeout counter reaches TIMEOUT_CYCLES, set stale, clear the seen mask, and saturate the counter.
REQ-022 SHALL clear stale in the same cycle frame_valid pulses.
REQ-023 SHALL use an FSM with states IDLE (illegal/blank com), SETTLE (counting), HELD (captured, awaiting change): IDLE->SETTLE on legal com; SETTLE->HELD at count; SETTLE/HELD->SETTLE on value change; any state->IDLE on illegal com.

Reset
REQ-024 SHALL, on reset, set digits=0, dp=0, digit_err=0, frame_valid=0, stale=0, clear the seen mask, shadow slots, settle and timeout counters and synchronizers, and force FSM=IDLE.
REQ-025 SHALL discard a partial frame when reset is asserted mid-frame, with no frame_valid after release until four new captures occur.

Configuration
REQ-026 SHALL, with SEG_DECODER_HEX_EN defined, additionally decode glyphs A,b,C,d,E,F to 4'hA-4'hF without error; without the macro those glyphs SHALL be treated as errors per REQ-015.

Structure
REQ-027 SHALL place segment glyph constants, com select codes and the FSM state typedef in package seg_pkg.
REQ-028 SHALL implement the glyph decode as combinational sub-module seg7_decode, which also carries the SEG_DECODER_HEX_EN option.

Verification
REQ-029 SHALL cover the normal scan: com 0111/1011/1101/1110 with num 10011111, 00100101, 00001101, 10011001, each held 10 clocks -> one frame_valid, digits=16'h1234, digit_err=0.
REQ-030 SHALL cover glitch rejection: a 2-clock num change inside a held phase with SETTLE_CYCLES=4 -> no extra capture, digits unchanged.
REQ-031 SHALL cover an invalid glyph: num=11111111 on tens -> digits[7:4]=4'hF and digit_err=0010 at frame_valid.
REQ-032 SHALL cover timeout: TIMEOUT_CYCLES=100, com held at 1111 for 100 clocks -> stale=1; the next complete frame -> stale=0 and frame_valid=1.
REQ-033 SHALL cover reset mid-frame: reset after 2 captures, then 4 captures -> exactly one frame_valid, carrying only post-reset values.
REQ-034 SHALL cover the macro: num=00010001 ('A') with SEG_DECODER_HEX_EN -> value 4'hA, error 0; without the macro -> 4'hF, error 1.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: digit-select codes,
// active-low glyph patterns (bit 6 = a ... bit 0 = g) and the scan FSM state type.
package seg_pkg;

  // Active-low digit-select codes on com
  localparam logic [3:0] ComThou  = 4'b0111;
  localparam logic [3:0] ComHund  = 4'b1011;
  localparam logic [3:0] ComTens  = 4'b1101;
  localparam logic [3:0] ComUnit  = 4'b1110;
  localparam logic [3:0] ComBlank = 4'b1111;

  // Active-low segment patterns, ordered a,b,c,d,e,f,g from MSB to LSB
  localparam logic [6:0] Glyph0 = 7'b0000001;
  localparam logic [6:0] Glyph1 = 7'b1001111;
  localparam logic [6:0] Glyph2 = 7'b0010010;
  localparam logic [6:0] Glyph3 = 7'b0000110;
  localparam logic [6:0] Glyph4 = 7'b1001100;
  localparam logic [6:0] Glyph5 = 7'b0100100;
  localparam logic [6:0] Glyph6 = 7'b0100000;
  localparam logic [6:0] Glyph7 = 7'b0001111;
  localparam logic [6:0] Glyph8 = 7'b0000000;
  localparam logic [6:0] Glyph9 = 7'b0000100;
  localparam logic [6:0] GlyphA = 7'b0001000;
  localparam logic [6:0] GlyphB = 7'b1100000;
  localparam logic [6:0] GlyphC = 7'b0110001;
  localparam logic [6:0] GlyphD = 7'b1000010;
  localparam logic [6:0] GlyphE = 7'b0110000;
  localparam logic [6:0] GlyphF = 7'b0111000;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHeld
  } scan_state_e;

  // A com code is legal only when exactly one digit is selected
  function automatic logic com_legal(input logic [3:0] com);
    logic legal;
    case (com)
      ComThou, ComHund, ComTens, ComUnit: legal = 1'b1;
      ComBlank:                           legal = 1'b0;
      default:                            legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Slot index of a legal com code; thousands is slot 3
  function automatic logic [1:0] com_to_slot(input logic [3:0] com);
    logic [1:0] slot;
    case (com)
      ComThou: slot = 2'd3;
      ComHund: slot = 2'd2;
      ComTens: slot = 2'd1;
      default: slot = 2'd0;
    endcase
    return slot;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment glyph decoder.
// Optional SEG_DECODER_HEX_EN accepts glyphs A,b,C,d,E,F as 4'hA-4'hF; otherwise they are errors.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       err
);

`ifdef SEG_DECODER_HEX_EN
  localparam bit HexEn = 1'b1;
`else
  localparam bit HexEn = 1'b0;
`endif

  // Map an active-low pattern to its value; anything unrecognised reads as F with error
  always_comb begin
    value = 4'hF;
    err   = 1'b1;
    case (seg)
      Glyph0: begin value = 4'h0; err = 1'b0; end
      Glyph1: begin value = 4'h1; err = 1'b0; end
      Glyph2: begin value = 4'h2; err = 1'b0; end
      Glyph3: begin value = 4'h3; err = 1'b0; end
      Glyph4: begin value = 4'h4; err = 1'b0; end
      Glyph5: begin value = 4'h5; err = 1'b0; end
      Glyph6: begin value = 4'h6; err = 1'b0; end
      Glyph7: begin value = 4'h7; err = 1'b0; end
      Glyph8: begin value = 4'h8; err = 1'b0; end
      Glyph9: begin value = 4'h9; err = 1'b0; end
      GlyphA: if (HexEn) begin value = 4'hA; err = 1'b0; end
      GlyphB: if (HexEn) begin value = 4'hB; err = 1'b0; end
      GlyphC: if (HexEn) begin value = 4'hC; err = 1'b0; end
      GlyphD: if (HexEn) begin value = 4'hD; err = 1'b0; end
      GlyphE: if (HexEn) begin value = 4'hE; err = 1'b0; end
      GlyphF: if (HexEn) begin value = 4'hF; err = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers four digits from a multiplexed seven-segment scan (active-low com/num).
// Each digit phase must be stable SETTLE_CYCLES samples before capture; a full set
// of four captures publishes a frame. Macro SEG_DECODER_HEX_EN enables hex glyphs.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  com,
  input  logic [7:0]  num,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        stale
);

  localparam logic [7:0]  SettleTarget = 8'(SETTLE_CYCLES);
  localparam logic [27:0] TimeoutMax   = 28'(TIMEOUT_CYCLES);

  logic [3:0]  com_meta, com_sync;
  logic [7:0]  num_meta, num_sync;
  logic [11:0] cur;
  logic        legal;

  scan_state_e state_q, state_d;
  logic [11:0] sample_q, sample_d;
  logic [7:0]  settle_q, settle_d;
  logic        capture;

  logic [3:0]  seen_q, seen_d;
  logic [3:0]  shadow_val_q [4];
  logic [3:0]  shadow_dp_q;
  logic [3:0]  shadow_err_q;
  logic [27:0] tmo_q, tmo_d;
  logic        tmo_hit;
  logic        frame_fire;
  logic        stale_d;

  logic [1:0]  slot;
  logic [3:0]  dec_value;
  logic        dec_err;

  // Two-flop synchronizer on the asynchronous display lines
  always_ff @(posedge clock) begin
    if (reset) begin
      com_meta <= 4'hF;
      com_sync <= 4'hF;
      num_meta <= 8'hFF;
      num_sync <= 8'hFF;
    end else begin
      com_meta <= com;
      com_sync <= com_meta;
      num_meta <= num;
      num_sync <= num_meta;
    end
  end

  assign cur   = {com_sync, num_sync};
  assign legal = com_legal(com_sync);

  // Scan FSM state, last sample and settle count
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      sample_q <= 12'hFFF;
      settle_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      settle_q <= settle_d;
    end
  end

  // Next-state: capture once when a legal value has been stable for SETTLE_CYCLES samples
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    settle_d = settle_q;
    capture  = 1'b0;
    if (!legal) begin
      state_d  = StIdle;
      settle_d = 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d  = StSettle;
          sample_d = cur;
          settle_d = 8'd1;
        end
        StSettle: begin
          if (cur != sample_q) begin
            sample_d = cur;
            settle_d = 8'd1;
          end else if (settle_q + 8'd1 == SettleTarget) begin
            capture  = 1'b1;
            state_d  = StHeld;
            settle_d = SettleTarget;
          end else begin
            settle_d = settle_q + 8'd1;
          end
        end
        StHeld: begin
          if (cur != sample_q) begin
            state_d  = StSettle;
            sample_d = cur;
            settle_d = 8'd1;
          end
        end
        default: begin
          state_d  = StIdle;
          settle_d = 8'd0;
        end
      endcase
    end
  end

  // At capture time the sample register equals the current synchronized value
  assign slot = com_to_slot(sample_q[11:8]);

  seg7_decode u_decode (
    .seg   (sample_q[7:1]),
    .value (dec_value),
    .err   (dec_err)
  );

  assign frame_fire = (seen_q == 4'hF);
  assign tmo_hit    = (tmo_q == TimeoutMax);

  // Seen mask, timeout counter and stale flag bookkeeping
  always_comb begin
    seen_d  = seen_q;
    tmo_d   = tmo_q;
    stale_d = stale;
    if (frame_fire || tmo_hit) begin
      seen_d = 4'h0;
    end
    if (capture) begin
      seen_d[slot] = 1'b1;
      tmo_d        = 28'd0;
    end else if (!tmo_hit) begin
      tmo_d = tmo_q + 28'd1;
    end
    if (tmo_hit) begin
      stale_d = 1'b1;
    end
    if (frame_fire) begin
      stale_d = 1'b0;
    end
  end

  // Shadow slots hold captures until the frame completes; recapture overwrites
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        shadow_val_q[i] <= 4'h0;
      end
      shadow_dp_q  <= 4'h0;
      shadow_err_q <= 4'h0;
    end else if (capture) begin
      shadow_val_q[slot] <= dec_value;
      shadow_dp_q[slot]  <= ~sample_q[0];
      shadow_err_q[slot] <= dec_err;
    end
  end

  // Frame publication, seen mask, timeout counter and stale flag
  always_ff @(posedge clock) begin
    if (reset) begin
      seen_q      <= 4'h0;
      tmo_q       <= 28'd0;
      stale       <= 1'b0;
      frame_valid <= 1'b0;
      digits      <= 16'h0;
      dp          <= 4'h0;
      digit_err   <= 4'h0;
    end else begin
      seen_q      <= seen_d;
      tmo_q       <= tmo_d;
      stale       <= stale_d;
      frame_valid <= frame_fire;
      if (frame_fire) begin
        digits    <= {shadow_val_q[3], shadow_val_q[2], shadow_val_q[1], shadow_val_q[0]};
        dp        <= shadow_dp_q;
        digit_err <= shadow_err_q;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with a frame scoreboard.
module tb_seg_scan_decoder;

  localparam logic [3:0] CThou  = 4'b0111;
  localparam logic [3:0] CHund  = 4'b1011;
  localparam logic [3:0] CTens  = 4'b1101;
  localparam logic [3:0] CUnit  = 4'b1110;
  localparam logic [3:0] CBlank = 4'b1111;

  // Active-low num bytes (a..g, dp) with dp dark
  localparam logic [7:0] G0 = 8'b00000011;
  localparam logic [7:0] G1 = 8'b10011111;
  localparam logic [7:0] G2 = 8'b00100101;
  localparam logic [7:0] G3 = 8'b00001101;
  localparam logic [7:0] G4 = 8'b10011001;
  localparam logic [7:0] G5 = 8'b01001001;
  localparam logic [7:0] G6 = 8'b01000001;
  localparam logic [7:0] G7 = 8'b00011111;
  localparam logic [7:0] G8 = 8'b00000001;
  localparam logic [7:0] G9 = 8'b00001001;
  localparam logic [7:0] GA = 8'b00010001;
  localparam logic [7:0] GX = 8'b11111111;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  com;
  logic [7:0]  num;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        stale;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  frame_t exp_q[$];
  int     checks   = 0;
  int     errors   = 0;
  int     fv_count = 0;
  logic   fv_prev  = 1'b0;

  seg_scan_decoder #(
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .com         (com),
    .num         (num),
    .digits      (digits),
    .dp          (dp),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic phase(input logic [3:0] c, input logic [7:0] n, input int hold);
    com = c;
    num = n;
    repeat (hold) @(negedge clock);
  endtask

  task automatic scan(input logic [7:0] n3, input logic [7:0] n2, input logic [7:0] n1,
                      input logic [7:0] n0);
    phase(CThou, n3, 10);
    phase(CHund, n2, 10);
    phase(CTens, n1, 10);
    phase(CUnit, n0, 10);
    phase(CBlank, GX, 4);
  endtask

  // Scoreboard: every frame_valid pulse pops and compares one expected frame
  always @(negedge clock) begin
    if (frame_valid === 1'b1) begin
      fv_count++;
      check("fv_one_cycle", {31'd0, fv_prev}, 32'd0);
      check("stale_clear_at_frame", {31'd0, stale}, 32'd0);
      check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        frame_t e;
        e = exp_q.pop_front();
        check("frame_digits", {16'd0, digits}, {16'd0, e.digits});
        check("frame_dp", {28'd0, dp}, {28'd0, e.dp});
        check("frame_err", {28'd0, digit_err}, {28'd0, e.err});
      end
    end
    fv_prev = frame_valid;
  end

  initial begin
    reset = 1'b1;
    com   = CBlank;
    num   = GX;
    repeat (3) @(negedge clock);
    check("rst_digits", {16'd0, digits}, 32'd0);
    check("rst_dp", {28'd0, dp}, 32'd0);
    check("rst_err", {28'd0, digit_err}, 32'd0);
    check("rst_fv", {31'd0, frame_valid}, 32'd0);
    check("rst_stale", {31'd0, stale}, 32'd0);
    reset = 1'b0;
    phase(CBlank, GX, 2);

    // Normal scan 1-2-3-4
    exp_q.push_back('{digits: 16'h1234, dp: 4'h0, err: 4'h0});
    scan(G1, G2, G3, G4);
    check("normal_count", fv_count, 1);
    phase(CBlank, GX, 20);
    check("hold_digits", {16'd0, digits}, 32'h1234);
    check("hold_count", fv_count, 1);

    // Two-clock glitch inside the thousands phase must not be captured
    exp_q.push_back('{digits: 16'h5678, dp: 4'h0, err: 4'h0});
    phase(CThou, G5, 5);
    phase(CThou, G9, 2);
    phase(CThou, G5, 3);
    phase(CHund, G6, 10);
    phase(CTens, G7, 10);
    phase(CUnit, G8, 10);
    phase(CBlank, GX, 4);
    check("glitch_count", fv_count, 2);

    // Blank glyph on tens, decimal point on hundreds
    exp_q.push_back('{digits: 16'h12F4, dp: 4'b0100, err: 4'b0010});
    scan(G1, 8'b00100100, GX, G4);
    check("invalid_count", fv_count, 3);

    // Hex glyph A on units
`ifdef SEG_DECODER_HEX_EN
    exp_q.push_back('{digits: 16'h098A, dp: 4'h0, err: 4'h0});
`else
    exp_q.push_back('{digits: 16'h098F, dp: 4'h0, err: 4'b0001});
`endif
    scan(G0, G9, G8, GA);
    check("hex_count", fv_count, 4);

    // Timeout: partial frame, scan stops, partial frame must be discarded
    phase(CThou, G7, 10);
    phase(CHund, G7, 10);
    phase(CTens, G7, 10);
    phase(CBlank, GX, 110);
    check("timeout_stale", {31'd0, stale}, 32'd1);
    check("timeout_count", fv_count, 4);
    phase(CUnit, G1, 10);
    phase(CBlank, GX, 10);
    check("timeout_mask_cleared", fv_count, 4);
    check("stale_held", {31'd0, stale}, 32'd1);
    exp_q.push_back('{digits: 16'h8061, dp: 4'h0, err: 4'h0});
    phase(CThou, G8, 10);
    phase(CHund, G0, 10);
    check("stale_before_frame", {31'd0, stale}, 32'd1);
    phase(CTens, G6, 10);
    phase(CBlank, GX, 4);
    check("recover_count", fv_count, 5);
    check("recover_stale", {31'd0, stale}, 32'd0);

    // Reset after two captures discards the partial frame
    phase(CThou, G9, 10);
    phase(CHund, G9, 10);
    reset = 1'b1;
    com   = CBlank;
    num   = GX;
    repeat (3) @(negedge clock);
    check("midrst_digits", {16'd0, digits}, 32'd0);
    check("midrst_dp", {28'd0, dp}, 32'd0);
    check("midrst_stale", {31'd0, stale}, 32'd0);
    reset = 1'b0;
    phase(CBlank, GX, 2);
    exp_q.push_back('{digits: 16'h3056, dp: 4'h0, err: 4'h0});
    phase(CTens, G2, 10);
    phase(CUnit, G6, 10);
    phase(CBlank, GX, 4);
    check("midrst_no_frame", fv_count, 5);
    phase(CTens, G5, 10);
    phase(CThou, G3, 10);
    phase(CHund, G0, 10);
    phase(CBlank, GX, 4);
    check("midrst_one_frame", fv_count, 6);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
